controller_sequencer: RTL

SAP-1 controller-sequencer: a six-state ring counter that steps each instruction through fetch (T1–T3) and execute (T4–T6) and decodes the instruction-register opcode into the active-high control word. Its enable outputs (Ep, Ei, Ea, Eu) drive the Enable inputs of the 8-bit tristate bus drivers that place the PC, IR operand, accumulator and ALU results on the W bus. Its load and count outputs drive the register, PC and RAM strobes.

---
 rtl/controller_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: six-state one-hot ring counter clocked on the falling
// edge, with a halt flag, plus a combinational decode of (T, opcode, halt) into the control word.
module controller_sequencer (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [3:0] opcode,
  output logic [5:0] T,
  output logic       Cp,
  output logic       Ep,
  output logic       Lm,
  output logic       CE,
  output logic       Li,
  output logic       Ei,
  output logic       La,
  output logic       Ea,
  output logic       Su,
  output logic       Eu,
  output logic       Lb,
  output logic       Lo,
  output logic       HLT
);

  localparam int unsigned NUM_STATES = 6;
  localparam int unsigned OP_W       = 4;

  localparam logic [NUM_STATES-1:0] T1 = 6'b000001;
  localparam logic [NUM_STATES-1:0] T2 = 6'b000010;
  localparam logic [NUM_STATES-1:0] T3 = 6'b000100;
  localparam logic [NUM_STATES-1:0] T4 = 6'b001000;
  localparam logic [NUM_STATES-1:0] T5 = 6'b010000;
  localparam logic [NUM_STATES-1:0] T6 = 6'b100000;

  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  logic [NUM_STATES-1:0] ring;
  logic                  halted;

  // Ring advances on the falling edge so the decode settles before the rising capture edge.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      ring   <= T1;
      halted <= 1'b0;
    end else if (!halted) begin
      if (!$onehot(ring)) begin
        ring <= T1;
      end else if (ring == T4 && opcode == OP_HLT) begin
        halted <= 1'b1;
      end else begin
        ring <= {ring[NUM_STATES-2:0], ring[NUM_STATES-1]};
      end
    end
  end

  assign T = ring;

  // Control word decode; an illegal (non one-hot) ring falls into the default and asserts nothing.
  always_comb begin
    Cp  = 1'b0;
    Ep  = 1'b0;
    Lm  = 1'b0;
    CE  = 1'b0;
    Li  = 1'b0;
    Ei  = 1'b0;
    La  = 1'b0;
    Ea  = 1'b0;
    Su  = 1'b0;
    Eu  = 1'b0;
    Lb  = 1'b0;
    Lo  = 1'b0;
    HLT = 1'b0;
    if (halted) begin
      HLT = 1'b1;
    end else begin
      case (ring)
        T1: begin
          Ep = 1'b1;
          Lm = 1'b1;
        end
        T2: Cp = 1'b1;
        T3: begin
          CE = 1'b1;
          Li = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              Ei = 1'b1;
              Lm = 1'b1;
            end
            OP_OUT: begin
              Ea = 1'b1;
              Lo = 1'b1;
            end
            OP_HLT:  HLT = 1'b1;
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              CE = 1'b1;
              La = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              CE = 1'b1;
              Lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              Eu = 1'b1;
              La = 1'b1;
            end
            OP_SUB: begin
              Su = 1'b1;
              Eu = 1'b1;
              La = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
